// File: rtl/config_mem_loader.sv
// Byte-stream command controller for the 102-byte configuration memory:
// parses WRITE/READ burst commands, drives the write port and streams read-back bytes.
module config_mem_loader #(
    parameter int MEM_DEPTH = 102,
    parameter int ADDR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MEM_DEPTH*8-1:0] mem_all_data,
    output logic [7:0]             mem_data_in,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_we,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   load_done,
    output logic                   err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        WRITE,
        READ
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [8:0]      DEPTH_L = 9'(MEM_DEPTH);

    state_t            state;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        cnt;
    logic              start_zero;
    logic              full_len;
    logic              burst_err;
    logic              accept;
    logic              addr_in_range;
    logic [7:0]        rd_byte;

    assign in_ready      = (state != READ);
    assign busy          = (state != IDLE);
    assign accept        = in_valid && in_ready;
    assign addr_in_range = ({1'b0, addr} < DEPTH_A);

    // Out-of-range addresses match no entry and read back as zero.
    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            if (addr == ADDR_W'(i)) rd_byte = mem_all_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            addr        <= '0;
            cnt         <= '0;
            start_zero  <= 1'b0;
            full_len    <= 1'b0;
            burst_err   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            load_done   <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (in_data)
                            8'h01: begin
                                is_write <= 1'b1;
                                state    <= ADDR;
                            end
                            8'h02: begin
                                is_write <= 1'b0;
                                state    <= ADDR;
                            end
                            8'h03:   err <= 1'b0;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ADDR: begin
                    if (accept) begin
                        addr       <= ADDR_W'(in_data);
                        start_zero <= (in_data == 8'h00);
                        state      <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (in_data == 8'h00) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt       <= in_data;
                            full_len  <= ({1'b0, in_data} >= DEPTH_L);
                            burst_err <= 1'b0;
                            state     <= is_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        mem_addr    <= addr;
                        mem_data_in <= in_data;
                        addr        <= addr + 1'b1;
                        cnt         <= cnt - 8'd1;
                        if (addr_in_range) begin
                            mem_we <= 1'b1;
                        end else begin
                            err       <= 1'b1;
                            burst_err <= 1'b1;
                        end
                        // The last byte's own range check must be folded in here,
                        // since burst_err for it only lands on this same edge.
                        if (cnt == 8'd1) begin
                            state <= IDLE;
                            if (start_zero && full_len && !burst_err && addr_in_range)
                                load_done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (!out_valid) begin
                        out_data  <= rd_byte;
                        out_valid <= 1'b1;
                        if (!addr_in_range) err <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        addr      <= addr + 1'b1;
                        cnt       <= cnt - 8'd1;
                        if (cnt == 8'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_mem_loader.sv
// Self-checking bench for config_mem_loader: directed scenarios plus randomized
// bursts checked against a simple address/byte model of the command protocol.
module tb_config_mem_loader;

    localparam int MEM_DEPTH = 102;
    localparam int ADDR_W    = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             in_data = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [MEM_DEPTH*8-1:0] mem_all_data;
    logic [7:0]             mem_data_in;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_we;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   busy;
    logic                   load_done;
    logic                   err;

    logic [7:0] mem_img [MEM_DEPTH];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic exp_ld = 1'b0;
    logic [7:0] obs_a[$];
    logic [7:0] obs_d[$];
    int         obs_c[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];

    config_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_all_data(mem_all_data), .mem_data_in(mem_data_in),
        .mem_addr(mem_addr), .mem_we(mem_we), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .load_done(load_done), .err(err)
    );

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_pack
        assign mem_all_data[g*8 +: 8] = mem_img[g];
    end

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            obs_a.push_back(mem_addr);
            obs_d.push_back(mem_data_in);
            obs_c.push_back(cyc);
        end
    end

    // Enter and leave at a negedge; the byte is accepted on the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL send_timeout byte=%02h in_ready never rose", b);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_d.delete(); obs_c.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    // Model: one expected write per in-range address, addresses wrap at 256.
    task automatic model_write(input int start, input int len, input logic [7:0] d[$],
                               output logic e);
        e = 1'b0;
        for (int k = 0; k < len; k++) begin
            int a = (start + k) % 256;
            if (a < MEM_DEPTH) begin
                exp_a.push_back(8'(a));
                exp_d.push_back(d[k]);
            end else begin
                e = 1'b1;
            end
        end
    endtask

    task automatic compare_writes(input string name);
        total++;
        if (obs_a.size() !== exp_a.size()) begin
            bad++;
            $display("FAIL %s_count got=%0d exp=%0d", name, obs_a.size(), exp_a.size());
        end else begin
            for (int k = 0; k < exp_a.size(); k++) begin
                total++;
                if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
                    bad++;
                    $display("FAIL %s_wr%0d got=%02h:%02h exp=%02h:%02h", name, k,
                             obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic write_burst(input int start, input int len, input logic [7:0] d[$]);
        send_byte(8'h01);
        send_byte(8'(start));
        send_byte(8'(len));
        for (int k = 0; k < len; k++) send_byte(d[k]);
        repeat (2) @(negedge clk);
    endtask

    task automatic recv_bytes(input string name, input int start, input int n, input bit bp);
        int k = 0;
        int ncyc = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        while (k < n && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s_in_ready got=%b exp=0", name, in_ready);
            end
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    total++;
                    if (out_data !== prev_data) begin
                        bad++;
                        $display("FAIL %s_stable got=%02h exp=%02h", name, out_data, prev_data);
                    end
                end
                if (out_ready) begin
                    int a = (start + k) % 256;
                    logic [7:0] e = (a < MEM_DEPTH) ? mem_img[a] : 8'h00;
                    total++;
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL %s_rd%0d got=%02h exp=%02h", name, k, out_data, e);
                    end
                    k++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                end
            end
        end
        total++;
        if (k < n) begin
            bad++;
            $display("FAIL %s_timeout got=%0d bytes exp=%0d", name, k, n);
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_end got=%b exp=0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mem_we, mem_addr, mem_data_in, out_valid, out_data, busy, load_done, err}
            !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_in got rdy=%b we=%b a=%02h d=%02h ov=%b od=%02h busy=%b ld=%b err=%b exp 1/0/00/00/0/00/0/0/0",
                     in_ready, mem_we, mem_addr, mem_data_in, out_valid, out_data, busy, load_done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_after got rdy=%b busy=%b we=%b err=%b exp 1/0/0/0",
                     in_ready, busy, mem_we, err);
        end
    endtask

    task automatic test_single_write();
        clear_obs();
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'hA5);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h05 || mem_data_in !== 8'hA5) begin
            bad++;
            $display("FAIL single_timing got we=%b a=%02h d=%02h exp 1/05/a5", mem_we, mem_addr, mem_data_in);
        end
        repeat (2) @(negedge clk);
        exp_a.push_back(8'h05); exp_d.push_back(8'hA5);
        compare_writes("single");
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL single_flags got busy=%b err=%b exp 0/0", busy, err);
        end
    endtask

    task automatic test_full_load();
        logic [7:0] d[$];
        logic e;
        clear_obs();
        for (int k = 0; k < MEM_DEPTH; k++) d.push_back(8'(k));
        model_write(0, MEM_DEPTH, d, e);
        exp_ld = !e;
        write_burst(0, MEM_DEPTH, d);
        compare_writes("full");
        total++;
        if (obs_c.size() == MEM_DEPTH && obs_c[MEM_DEPTH-1] - obs_c[0] !== MEM_DEPTH - 1) begin
            bad++;
            $display("FAIL full_b2b got span=%0d exp=%0d", obs_c[MEM_DEPTH-1] - obs_c[0], MEM_DEPTH - 1);
        end
        total++;
        if (load_done !== exp_ld || err !== e) begin
            bad++;
            $display("FAIL full_flags got ld=%b err=%b exp %b/%b", load_done, err, exp_ld, e);
        end
    endtask

    task automatic test_read_backpressure();
        mem_img[10] = 8'h3C;
        mem_img[11] = 8'h7E;
        out_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h0A);
        send_byte(8'h02);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rdbp_enter got rdy=%b ov=%b exp 0/0", in_ready, out_valid);
        end
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL rdbp_hold got ov=%b od=%02h rdy=%b exp 1/3c/0", out_valid, out_data, in_ready);
            end
        end
        recv_bytes("rdbp", 10, 2, 1'b0);
    endtask

    task automatic test_out_of_range();
        logic [7:0] d[$];
        logic e;
        clear_obs();
        for (int k = 0; k < 4; k++) d.push_back(8'($urandom));
        model_write(100, 4, d, e);
        write_burst(100, 4, d);
        compare_writes("oor");
        total++;
        if (err !== e || e !== 1'b1) begin
            bad++;
            $display("FAIL oor_err got=%b exp=%b", err, e);
        end
        send_byte(8'h03);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL oor_clr got=%b exp=0", err);
        end
    endtask

    task automatic test_illegal();
        send_byte(8'h7F);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ill_op got err=%b busy=%b exp 1/0", err, busy);
        end
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h00);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ill_len got err=%b busy=%b rdy=%b exp 1/0/1", err, busy, in_ready);
        end
        send_byte(8'h03);
        send_byte(8'h03);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL ill_clr got=%b exp=0", err);
        end
    endtask

    task automatic test_random_bursts();
        for (int it = 0; it < 16; it++) begin
            int start = $urandom_range(0, 1) ? int'($urandom_range(0, MEM_DEPTH - 1))
                                             : int'($urandom_range(96, 255));
            int len = $urandom_range(1, 8);
            logic e = 1'b0;
            if ($urandom_range(0, 1)) begin
                logic [7:0] d[$];
                clear_obs();
                for (int k = 0; k < len; k++) d.push_back(8'($urandom));
                model_write(start, len, d, e);
                write_burst(start, len, d);
                compare_writes("rnd_wr");
            end else begin
                for (int k = 0; k < len; k++) if ((start + k) % 256 >= MEM_DEPTH) e = 1'b1;
                send_byte(8'h02);
                send_byte(8'(start));
                send_byte(8'(len));
                recv_bytes("rnd_rd", start, len, 1'b1);
            end
            total++;
            if (err !== e || load_done !== exp_ld) begin
                bad++;
                $display("FAIL rnd_flags it=%0d got err=%b ld=%b exp %b/%b", it, err, load_done, e, exp_ld);
            end
            send_byte(8'h03);
        end
    endtask

    task automatic test_reset_mid_burst();
        send_byte(8'h01);
        send_byte(8'h14);
        send_byte(8'h08);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        rst_n = 1'b0;
        exp_ld = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || load_done !== exp_ld || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL midrst got we=%b busy=%b rdy=%b ld=%b a=%02h exp 0/0/1/0/00",
                     mem_we, busy, in_ready, load_done, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h5A);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_data_in !== 8'h5A || err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after got we=%b a=%02h d=%02h err=%b exp 1/30/5a/0",
                     mem_we, mem_addr, mem_data_in, err);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem_img[i] = 8'($urandom);
        test_reset();
        test_single_write();
        test_full_load();
        test_read_backpressure();
        test_out_of_range();
        test_illegal();
        test_random_bursts();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
